// File: rtl/traffic_phase_timer.sv
// Phase timer/sequencer for traffic_light_fsm.
// Watches the FSM's one-hot phase inputs. It times the active phase in whole seconds and
// raises the matching *_end level when that phase has run its programmed duration.
//
// Ports:
//   clk, rst_n                              clock, async active-low reset
//   state_green/yellow/red                  FSM phase one-hot
//   green_end/yellow_end/red_end            active phase duration expired (level)
//   cfg_valid/cfg_ready                     duration write handshake
//   cfg_sel, cfg_value                      write target (0=G,1=Y,2=R,3=illegal), seconds
//   cfg_err                                 1-cycle pulse: illegal target accepted
//   ped_req, ped_ack                        pedestrian request level / service pulse
//   time_left                               seconds remaining in the current phase
//   phase_err                               phase inputs not one-hot
module traffic_phase_timer #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned GREEN_DEF  = 30,
  parameter int unsigned YELLOW_DEF = 3,
  parameter int unsigned RED_DEF    = 30,
  parameter int unsigned PED_MIN    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             state_green,
  input  logic             state_yellow,
  input  logic             state_red,
  output logic             green_end,
  output logic             yellow_end,
  output logic             red_end,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_value,
  output logic             cfg_err,
  input  logic             ped_req,
  output logic             ped_ack,
  output logic [CNT_W-1:0] time_left,
  output logic             phase_err
);

  localparam int unsigned      PRE_W     = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] PED_MIN_C = CNT_W'(PED_MIN);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [2:0]       expired_q, expired_d;  // {green, yellow, red}
  logic [CNT_W-1:0] dur_g_q, dur_g_d, dur_y_q, dur_y_d, dur_r_q, dur_r_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_ack_q, ped_ack_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             cfg_err_q, cfg_err_d;
  logic             phase_err_q, phase_err_d;

  logic [2:0]       cur;
  logic             valid, phase_chg, tick, cfg_accept, ped_seen;
  logic [CNT_W-1:0] load_val, cfg_dur;

  assign cur        = {state_green, state_yellow, state_red};
  assign valid      = (cur == 3'b100) || (cur == 3'b010) || (cur == 3'b001);
  assign phase_chg  = valid && (cur != prev_q);
  assign tick       = (pre_q == TICK_LAST);
  assign cfg_accept = cfg_valid && cfg_ready_q;
  assign cfg_dur    = (cfg_value == '0) ? ONE : cfg_value;
  // A request raised this cycle is serviced this cycle, not one cycle later.
  assign ped_seen   = ped_pend_q || ped_req;

  // Shadow durations are read before this edge's config write lands.
  always_comb begin
    case (cur)
      3'b100:  load_val = dur_g_q;
      3'b010:  load_val = dur_y_q;
      default: load_val = dur_r_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    pre_d       = pre_q;
    left_d      = left_q;
    expired_d   = expired_q;
    dur_g_d     = dur_g_q;
    dur_y_d     = dur_y_q;
    dur_r_d     = dur_r_q;
    ped_pend_d  = ped_seen;
    ped_ack_d   = 1'b0;
    cfg_ready_d = !cfg_accept;
    cfg_err_d   = cfg_accept && (cfg_sel == 2'd3);
    phase_err_d = phase_err_q;

    if (cfg_accept) begin
      unique case (cfg_sel)
        2'd0:    dur_g_d = cfg_dur;
        2'd1:    dur_y_d = cfg_dur;
        2'd2:    dur_r_d = cfg_dur;
        default: ;
      endcase
    end

    if (!valid) begin
      // Counters freeze; timing resumes when a legal phase returns.
      state_d     = StIdle;
      phase_err_d = 1'b1;
      expired_d   = '0;
    end else if (phase_chg) begin
      state_d     = StRun;
      prev_d      = cur;
      left_d      = load_val;
      pre_d       = '0;
      expired_d   = '0;
      phase_err_d = 1'b0;
    end else begin
      phase_err_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          // Same phase back after a glitch: resume, or re-assert its end if already expired.
          if (left_q == '0) begin
            state_d   = StDone;
            expired_d = cur;
          end else begin
            state_d = StRun;
          end
        end
        StRun: begin
          pre_d = tick ? '0 : pre_q + PRE_W'(1);
          if (cur[2] && ped_seen && (left_q > PED_MIN_C)) begin
            left_d     = PED_MIN_C;
            ped_pend_d = 1'b0;
            ped_ack_d  = 1'b1;
          end else if (tick) begin
            if (left_q <= ONE) begin
              left_d    = '0;
              expired_d = cur;
              state_d   = StDone;
              if (cur[2] && ped_seen) begin
                ped_pend_d = 1'b0;
                ped_ack_d  = 1'b1;
              end
            end else begin
              left_d = left_q - ONE;
            end
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      prev_q      <= '0;
      pre_q       <= '0;
      left_q      <= '0;
      expired_q   <= '0;
      dur_g_q     <= CNT_W'(GREEN_DEF);
      dur_y_q     <= CNT_W'(YELLOW_DEF);
      dur_r_q     <= CNT_W'(RED_DEF);
      ped_pend_q  <= 1'b0;
      ped_ack_q   <= 1'b0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      phase_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pre_q       <= pre_d;
      left_q      <= left_d;
      expired_q   <= expired_d;
      dur_g_q     <= dur_g_d;
      dur_y_q     <= dur_y_d;
      dur_r_q     <= dur_r_d;
      ped_pend_q  <= ped_pend_d;
      ped_ack_q   <= ped_ack_d;
      cfg_ready_q <= cfg_ready_d;
      cfg_err_q   <= cfg_err_d;
      phase_err_q <= phase_err_d;
    end
  end

  assign green_end  = expired_q[2];
  assign yellow_end = expired_q[1];
  assign red_end    = expired_q[0];
  assign cfg_ready  = cfg_ready_q;
  assign cfg_err    = cfg_err_q;
  assign ped_ack    = ped_ack_q;
  assign time_left  = left_q;
  assign phase_err  = phase_err_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Self-checking bench for traffic_phase_timer with TICK_DIV=4 and default durations.
module tb_traffic_phase_timer;
  localparam int TICK_DIV = 4;
  localparam int GREEN_DEF = 30;
  localparam int YELLOW_DEF = 3;
  localparam int RED_DEF = 30;
  localparam int PED_MIN = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       g = 1'b0, y = 1'b0, r = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [7:0] cfg_value = 8'd0;
  logic       ped_req = 1'b0;
  logic       green_end, yellow_end, red_end, cfg_ready, cfg_err, ped_ack, phase_err;
  logic [7:0] time_left;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .TICK_DIV(TICK_DIV), .CNT_W(8), .GREEN_DEF(GREEN_DEF), .YELLOW_DEF(YELLOW_DEF),
    .RED_DEF(RED_DEF), .PED_MIN(PED_MIN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .state_green(g), .state_yellow(y), .state_red(r),
    .green_end(green_end), .yellow_end(yellow_end), .red_end(red_end),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel), .cfg_value(cfg_value),
    .cfg_err(cfg_err), .ped_req(ped_req), .ped_ack(ped_ack),
    .time_left(time_left), .phase_err(phase_err)
  );

  // Reference model: seconds remaining, cycles into the current second, and flags.
  bit         m_timing, m_expired, m_err, m_pend, m_ack, m_ready, m_cerr;
  logic [2:0] m_prev, m_end;
  int         m_left, m_div;
  int         m_dur[3];

  logic [14:0] dut_vec;
  assign dut_vec = {green_end, yellow_end, red_end, time_left, phase_err, cfg_ready, cfg_err,
                    ped_ack};

  function automatic logic [14:0] mdl_vec();
    return {m_end, 8'(m_left), m_err, m_ready, m_cerr, m_ack};
  endfunction

  task automatic model_reset();
    m_timing = 0; m_expired = 0; m_err = 0; m_pend = 0; m_ack = 0; m_ready = 0; m_cerr = 0;
    m_prev = 3'b000; m_end = 3'b000; m_left = 0; m_div = 0;
    m_dur = '{GREEN_DEF, YELLOW_DEF, RED_DEF};
  endtask

  // Advance one clock: update the model from the inputs seen at this edge.
  task automatic step();
    logic [2:0] cur;
    bit valid, accept, pe, tick;
    int idx;
    int nd[3];
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      cur = {g, y, r};
      valid = ($countones(cur) == 1);
      idx = cur[2] ? 0 : (cur[1] ? 1 : 2);
      nd = m_dur;
      accept = cfg_valid && m_ready;
      m_ready = !accept;
      m_cerr = accept && (cfg_sel == 2'd3);
      m_ack = 0;
      if (accept && cfg_sel != 2'd3) nd[cfg_sel] = (cfg_value == 0) ? 1 : int'(cfg_value);
      pe = m_pend || ped_req;
      m_pend = pe;
      if (!valid) begin
        m_err = 1; m_end = 0; m_timing = 0; m_expired = 0;
      end else if (cur != m_prev) begin
        m_prev = cur; m_left = m_dur[idx]; m_div = 0; m_end = 0; m_err = 0;
        m_timing = 1; m_expired = 0;
      end else begin
        m_err = 0;
        if (!m_timing && !m_expired) begin
          if (m_left == 0) begin m_expired = 1; m_end = cur; end
          else m_timing = 1;
        end else if (m_timing) begin
          tick = (m_div == TICK_DIV - 1);
          m_div = tick ? 0 : m_div + 1;
          if (cur[2] && pe && m_left > PED_MIN) begin
            m_left = PED_MIN; m_pend = 0; m_ack = 1;
          end else if (tick) begin
            if (m_left <= 1) begin
              m_left = 0; m_end = cur; m_timing = 0; m_expired = 1;
              if (cur[2] && pe) begin m_pend = 0; m_ack = 1; end
            end else begin
              m_left = m_left - 1;
            end
          end
        end
      end
      m_dur = nd;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; {g, y, r} = 3'b000; cfg_valid = 0; ped_req = 0;
    model_reset();
    step(); step();
    rst_n = 1;
  endtask

  // Steps until the selected end (0=G,1=Y,2=R) is seen or the bound expires.
  task automatic run_until(input int which, input int bound, output int cnt);
    cnt = 0;
    while (!(which == 0 ? green_end : (which == 1 ? yellow_end : red_end)) && cnt < bound) begin
      step();
      cnt++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; {g, y, r} = 3'b000; cfg_valid = 0; ped_req = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 15'h0) $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 15'h0);
    else passes++;
    step(); step();
    rst_n = 1;
    #1;
    checks++;
    if (cfg_ready !== 1'b0) $display("FAIL ready_before_edge got=%b exp=0", cfg_ready);
    else passes++;
    step();
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL ready_after_release got=%b exp=1", cfg_ready);
    else passes++;
    checks++;
    if (dut_vec !== mdl_vec()) $display("FAIL reset_model got=%h exp=%h", dut_vec, mdl_vec());
    else passes++;
  endtask

  task automatic test_green_timing();
    int cnt;
    apply_reset();
    g = 1;
    step();
    checks++;
    if (time_left !== 8'(GREEN_DEF)) $display("FAIL green_load got=%0d exp=%0d", time_left, GREEN_DEF);
    else passes++;
    run_until(0, 200, cnt);
    checks++;
    if (cnt != GREEN_DEF * TICK_DIV) $display("FAIL green_latency got=%0d exp=%0d", cnt, GREEN_DEF * TICK_DIV);
    else passes++;
    step(); step(); step();
    g = 0; y = 1;
    checks++;
    if (green_end !== 1'b1) $display("FAIL green_end_held got=%b exp=1", green_end);
    else passes++;
    step();
    checks++;
    if (green_end !== 1'b0) $display("FAIL green_end_fall got=%b exp=0", green_end);
    else passes++;
    checks++;
    if (time_left !== 8'(YELLOW_DEF)) $display("FAIL yellow_load got=%0d exp=%0d", time_left, YELLOW_DEF);
    else passes++;
  endtask

  task automatic test_full_cycle();
    int ychg, rchg, ylat, rlat, overlap, mism;
    ychg = -1; rchg = -1; ylat = -1; rlat = -1; overlap = 0; mism = 0;
    apply_reset();
    g = 1;
    for (int c = 0; c < 300; c++) begin
      step();
      if ($countones({green_end, yellow_end, red_end}) > 1) overlap++;
      if (dut_vec !== mdl_vec()) mism++;
      if (yellow_end && ylat < 0 && ychg >= 0) ylat = c - ychg;
      if (red_end && rlat < 0 && rchg >= 0) rlat = c - rchg;
      if (green_end && g) begin g = 0; y = 1; ychg = c + 1; end
      else if (yellow_end && y) begin y = 0; r = 1; rchg = c + 1; end
      else if (red_end && r) begin r = 0; g = 1; end
    end
    checks++;
    if (ylat != YELLOW_DEF * TICK_DIV) $display("FAIL yellow_latency got=%0d exp=%0d", ylat, YELLOW_DEF * TICK_DIV);
    else passes++;
    checks++;
    if (rlat != RED_DEF * TICK_DIV) $display("FAIL red_latency got=%0d exp=%0d", rlat, RED_DEF * TICK_DIV);
    else passes++;
    checks++;
    if (overlap != 0) $display("FAIL end_overlap got=%0d exp=0", overlap);
    else passes++;
    checks++;
    if (mism != 0) $display("FAIL cycle_model got=%0d mismatches exp=0", mism);
    else passes++;
  endtask

  task automatic test_config();
    int cnt;
    apply_reset();
    g = 1;
    step();
    for (int i = 0; i < 6; i++) step();
    cfg_valid = 1; cfg_sel = 2'd1; cfg_value = 8'd0;
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_idle got=%b exp=1", cfg_ready);
    else passes++;
    step();
    cfg_valid = 0;
    checks++;
    if (cfg_ready !== 1'b0) $display("FAIL cfg_ready_low got=%b exp=0", cfg_ready);
    else passes++;
    checks++;
    if (time_left !== 8'(GREEN_DEF - 7 / TICK_DIV)) $display("FAIL green_unchanged got=%0d exp=%0d", time_left, GREEN_DEF - 7 / TICK_DIV);
    else passes++;
    step();
    checks++;
    if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_back got=%b exp=1", cfg_ready);
    else passes++;
    cfg_valid = 1; cfg_sel = 2'd3; cfg_value = 8'd9;
    step();
    cfg_valid = 0;
    checks++;
    if (cfg_err !== 1'b1) $display("FAIL cfg_err_pulse got=%b exp=1", cfg_err);
    else passes++;
    step();
    checks++;
    if (cfg_err !== 1'b0) $display("FAIL cfg_err_clear got=%b exp=0", cfg_err);
    else passes++;
    run_until(0, 200, cnt);
    // Write lands on the same edge as the yellow load: the old value (1 s) is used.
    g = 0; y = 1; cfg_valid = 1; cfg_sel = 2'd1; cfg_value = 8'd7;
    step();
    cfg_valid = 0;
    run_until(1, 100, cnt);
    checks++;
    if (cnt != TICK_DIV) $display("FAIL short_yellow got=%0d exp=%0d", cnt, TICK_DIV);
    else passes++;
    y = 0; r = 1; step(); run_until(2, 200, cnt);
    r = 0; g = 1; step(); run_until(0, 200, cnt);
    g = 0; y = 1; step(); run_until(1, 100, cnt);
    checks++;
    if (cnt != 7 * TICK_DIV) $display("FAIL new_yellow got=%0d exp=%0d", cnt, 7 * TICK_DIV);
    else passes++;
  endtask

  task automatic test_ped();
    int cnt, n;
    apply_reset();
    g = 1;
    step();
    n = 0;
    while (m_left != 20 && n < 200) begin step(); n++; end
    ped_req = 1;
    step();
    ped_req = 0;
    checks++;
    if (time_left !== 8'(PED_MIN)) $display("FAIL ped_shorten got=%0d exp=%0d", time_left, PED_MIN);
    else passes++;
    checks++;
    if (ped_ack !== 1'b1) $display("FAIL ped_ack_pulse got=%b exp=1", ped_ack);
    else passes++;
    step();
    checks++;
    if (ped_ack !== 1'b0) $display("FAIL ped_ack_clear got=%b exp=0", ped_ack);
    else passes++;
    run_until(0, 200, cnt);
    // The request landed one cycle after a tick, so 5 ticks end one cycle early.
    checks++;
    if (cnt + 1 != PED_MIN * TICK_DIV - 1) $display("FAIL ped_green_end got=%0d exp=%0d", cnt + 1, PED_MIN * TICK_DIV - 1);
    else passes++;

    apply_reset();
    g = 1;
    step();
    n = 0;
    while (m_left != 3 && n < 200) begin step(); n++; end
    ped_req = 1;
    step();
    ped_req = 0;
    checks++;
    if (time_left !== 8'd3 || ped_ack !== 1'b0) $display("FAIL ped_late_nochange got=%0d/%b exp=3/0", time_left, ped_ack);
    else passes++;
    run_until(0, 100, cnt);
    checks++;
    if (green_end !== 1'b1 || ped_ack !== 1'b1) $display("FAIL ped_ack_at_end got=%b/%b exp=1/1", green_end, ped_ack);
    else passes++;
    step();
    checks++;
    if (ped_ack !== 1'b0) $display("FAIL ped_ack_end_clear got=%b exp=0", ped_ack);
    else passes++;
  endtask

  task automatic test_phase_err();
    int held, cnt;
    apply_reset();
    g = 1;
    step();
    for (int i = 0; i < 10; i++) step();
    held = m_left;
    y = 1;
    step();
    checks++;
    if (phase_err !== 1'b1 || {green_end, yellow_end, red_end} !== 3'b000) $display("FAIL phase_err_set got=%b/%b exp=1/000", phase_err, {green_end, yellow_end, red_end});
    else passes++;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (time_left !== 8'(held)) $display("FAIL frozen_left got=%0d exp=%0d", time_left, held);
    else passes++;
    y = 0;
    step();
    checks++;
    if (time_left !== 8'(held)) $display("FAIL resume_left got=%0d exp=%0d", time_left, held);
    else passes++;
    run_until(0, 200, cnt);
    checks++;
    if (dut_vec !== mdl_vec()) $display("FAIL resume_end got=%h exp=%h", dut_vec, mdl_vec());
    else passes++;
  endtask

  task automatic test_async_reset();
    int cnt;
    apply_reset();
    g = 1;
    step();
    run_until(0, 200, cnt);
    g = 0; y = 1;
    step();
    for (int i = 0; i < 5; i++) step();
    #2 rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 15'h0) $display("FAIL async_reset got=%h exp=%h", dut_vec, 15'h0);
    else passes++;
    step(); step(); step();
    rst_n = 1;
    step();
    checks++;
    if (time_left !== 8'(YELLOW_DEF)) $display("FAIL restart_load got=%0d exp=%0d", time_left, YELLOW_DEF);
    else passes++;
    run_until(1, 100, cnt);
    checks++;
    if (cnt != YELLOW_DEF * TICK_DIV) $display("FAIL restart_latency got=%0d exp=%0d", cnt, YELLOW_DEF * TICK_DIV);
    else passes++;
  endtask

  task automatic test_random();
    int mism, overlap;
    bit glitch;
    logic [2:0] saved;
    mism = 0; overlap = 0; glitch = 0; saved = 3'b100;
    apply_reset();
    g = 1;
    for (int c = 0; c < 2500; c++) begin
      step();
      if (dut_vec !== mdl_vec()) begin
        if (mism < 4) $display("FAIL random_trace c=%0d got=%h exp=%h", c, dut_vec, mdl_vec());
        mism++;
      end
      if ($countones({green_end, yellow_end, red_end}) > 1) overlap++;
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_value = 8'($urandom_range(0, 6));
      ped_req = ($urandom_range(0, 19) == 0);
      if (glitch) begin
        {g, y, r} = saved; glitch = 0;
      end else if ($urandom_range(0, 99) == 0) begin
        saved = {g, y, r};
        {g, y, r} = ($urandom_range(0, 1) == 1) ? 3'b110 : 3'b000;
        glitch = 1;
      end else if (green_end && g) begin g = 0; y = 1; end
      else if (yellow_end && y) begin y = 0; r = 1; end
      else if (red_end && r) begin r = 0; g = 1; end
    end
    cfg_valid = 0; ped_req = 0;
    checks++;
    if (mism != 0) $display("FAIL random_model got=%0d mismatches exp=0", mism);
    else passes++;
    checks++;
    if (overlap != 0) $display("FAIL random_overlap got=%0d exp=0", overlap);
    else passes++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_green_timing();
    test_full_cycle();
    test_config();
    test_ped();
    test_phase_err();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
